// File: rtl/bridge_seq_pkg.sv
// ---------------------------------------------------------------------------
// bridge_seq_pkg: command codes, state encodings and leg patterns. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bridge_seq_pkg;

  typedef enum logic [2:0] {
    CMD_PAUSE = 3'd0,
    CMD_PLUS  = 3'd1,
    CMD_MINUS = 3'd2,
    CMD_BALP  = 3'd3,
    CMD_BALN  = 3'd4,
    CMD_START = 3'd5,
    CMD_SHUT  = 3'd6,
    CMD_DIS   = 3'd7
  } cmd_code_t;

  typedef enum logic [3:0] {
    RX_IDLE  = 4'd0,
    RX_PAUSE = 4'd1,
    RX_START = 4'd2,
    RX_DIS0  = 4'd3,
    RX_DIS1  = 4'd4,
    RX_DIS2  = 4'd5,
    RX_DIS3  = 4'd6,
    RX_CLR   = 4'd7,
    RX_ERROR = 4'd8
  } rx_state_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_PC = 2'd1,
    S_WAIT_ST = 2'd2
  } start_state_t;

  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
  } leg_pattern_t;

  localparam leg_pattern_t PAT_OFF   = '{top: 4'b0000, bot: 4'b0000};
  localparam leg_pattern_t PAT_PLUS  = '{top: 4'b0001, bot: 4'b0010};
  localparam leg_pattern_t PAT_MINUS = '{top: 4'b0010, bot: 4'b0001};
  localparam leg_pattern_t PAT_BALP  = '{top: 4'b0100, bot: 4'b1000};
  localparam leg_pattern_t PAT_BALN  = '{top: 4'b1000, bot: 4'b0100};

endpackage

`default_nettype wire

// File: rtl/bridge_deadtime.sv
// ---------------------------------------------------------------------------
// bridge_deadtime: inserts an all-off gap between differing leg patterns. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bridge_deadtime
  import bridge_seq_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC = 50,
  parameter int unsigned TW           = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [7:0] req_pattern,
  input  logic       kill,
  output logic [7:0] gates_out
);

  localparam logic [TW-1:0] DT_LOAD = TW'(DEADTIME_CYC);

  leg_pattern_t  req;
  leg_pattern_t  gates_q, gates_d;
  leg_pattern_t  pending_q, pending_d;
  logic          pending_valid_q, pending_valid_d;
  logic [TW-1:0] cnt_q, cnt_d;

  assign req       = leg_pattern_t'(req_pattern);
  assign gates_out = gates_q;

  always_comb begin
    gates_d         = gates_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    cnt_d           = cnt_q;

    if (pending_valid_q) begin
      if (cnt_q <= TW'(1)) begin
        gates_d         = pending_q;
        pending_d       = PAT_OFF;
        pending_valid_d = 1'b0;
        cnt_d           = '0;
      end else begin
        cnt_d = cnt_q - TW'(1);
      end
    end

    if (kill || (req_valid && req == PAT_OFF)) begin
      gates_d         = PAT_OFF;
      pending_d       = PAT_OFF;
      pending_valid_d = 1'b0;
      cnt_d           = '0;
    end else if (req_valid) begin
      // During a gap the newest request replaces the pending one without restarting it
      if (pending_valid_q) begin
        if (cnt_q <= TW'(1)) begin
          gates_d = req;
        end else begin
          pending_d = req;
        end
      end else if (gates_q == PAT_OFF || gates_q == req || DEADTIME_CYC == 0) begin
        gates_d = req;
      end else begin
        gates_d         = PAT_OFF;
        pending_d       = req;
        pending_valid_d = 1'b1;
        cnt_d           = DT_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gates_q         <= PAT_OFF;
      pending_q       <= PAT_OFF;
      pending_valid_q <= 1'b0;
      cnt_q           <= '0;
    end else begin
      gates_q         <= gates_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      cnt_q           <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bridge_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bridge_seq_ctrl: H-bridge command decoder, start sequencer, faults, LEDs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bridge_seq_ctrl
  import bridge_seq_pkg::*;
#(
  parameter int unsigned         N_FAULT         = 8,
  parameter logic [N_FAULT-1:0]  FAULT_MASK      = '1,
  parameter int unsigned         PRECHARGE_CYC   = 750000000,
  parameter int unsigned         SETTLE_CYC      = 50000000,
  parameter int unsigned         DEADTIME_CYC    = 50,
  parameter int unsigned         SEQ_TIMEOUT_CYC = 5000000,
  parameter int unsigned         LED_NORMAL      = 50000000,
  parameter int unsigned         LED_ERROR       = 6250000,
  parameter int unsigned         TW              = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               bus_clk,
  input  logic [2:0]         bus_data,
  input  logic [N_FAULT-1:0] fault,
  output logic [3:0]         o_top,
  output logic [3:0]         o_bot,
  output logic               o_plus,
  output logic               o_minus,
  output logic               o_pause_p,
  output logic               o_pause_n,
  output logic               o_st,
  output logic               o_ch,
  output logic               o_fan,
  output logic               o_break,
  output logic [N_FAULT-1:0] fault_latch,
  output logic               led_ready,
  output logic               led_done
);

  if (((PRECHARGE_CYC | SETTLE_CYC | DEADTIME_CYC | SEQ_TIMEOUT_CYC |
        LED_NORMAL | LED_ERROR) >> TW) != 0) begin : g_tw_check
    $error("bridge_seq_ctrl: a cycle parameter does not fit in TW bits");
  end

  localparam logic [TW-1:0] PRE_LD  = TW'(PRECHARGE_CYC);
  localparam logic [TW-1:0] SET_LD  = TW'(SETTLE_CYC);
  localparam logic [TW-1:0] SEQ_LD  = TW'(SEQ_TIMEOUT_CYC);
  localparam logic [TW-1:0] LEDN_LD = TW'(LED_NORMAL);
  localparam logic [TW-1:0] LEDE_LD = TW'(LED_ERROR);

  logic               bus_clk_q;
  rx_state_t          rx_q, rx_d;
  start_state_t       start_q, start_d;
  logic [TW-1:0]      timer_q, timer_d, timer_dec;
  logic [TW-1:0]      gap_q, gap_d;
  logic [TW-1:0]      led_cnt_q, led_cnt_d;
  logic [3:0]         mode_q, mode_d;  // {pause_n, pause_p, minus, plus}
  logic               st_q, st_d, ch_q, ch_d, fan_q, fan_d, brk_q, brk_d;
  logic               led_q, led_d, done_q, done_d;
  logic [N_FAULT-1:0] latch_q, latch_d;

  logic               strobe, run_ok, req_valid, kill;
  leg_pattern_t       req_pattern, gates;
  logic [7:0]         gates_w;
  cmd_code_t          sym;
  logic [N_FAULT-1:0] trip;

  assign strobe = bus_clk_q & ~bus_clk;
  assign sym    = cmd_code_t'(bus_data);
  assign trip   = fault & FAULT_MASK;
  assign run_ok = (start_q == S_IDLE) && st_q && !ch_q;

  always_comb begin
    rx_d        = rx_q;
    start_d     = start_q;
    mode_d      = mode_q;
    st_d        = st_q;
    ch_d        = ch_q;
    fan_d       = fan_q;
    brk_d       = brk_q;
    latch_d     = latch_q;
    req_valid   = 1'b0;
    req_pattern = PAT_OFF;
    kill        = 1'b0;
    timer_dec   = (timer_q == '0) ? '0 : timer_q - TW'(1);
    timer_d     = timer_dec;
    gap_d       = (gap_q == '0) ? '0 : gap_q - TW'(1);

    // Phases end in the cycle the timer reaches zero, so each phase lasts exactly its load value
    case (start_q)
      S_WAIT_PC: if (timer_dec == '0) begin
        st_d    = 1'b1;
        timer_d = SET_LD;
        start_d = S_WAIT_ST;
      end
      S_WAIT_ST: if (timer_dec == '0) begin
        ch_d    = 1'b0;
        start_d = S_IDLE;
      end
      default: ;
    endcase

    if (strobe) begin
      gap_d = SEQ_LD;
      rx_d  = RX_IDLE;
      case (rx_q)
        RX_IDLE: begin
          case (sym)
            CMD_PAUSE: rx_d = RX_PAUSE;
            CMD_PLUS:  if (run_ok) begin req_valid = 1'b1; req_pattern = PAT_PLUS;  mode_d = 4'b0001; end
            CMD_MINUS: if (run_ok) begin req_valid = 1'b1; req_pattern = PAT_MINUS; mode_d = 4'b0010; end
            CMD_BALP:  if (run_ok) begin req_valid = 1'b1; req_pattern = PAT_BALP;  mode_d = 4'b0100; end
            CMD_BALN:  if (run_ok) begin req_valid = 1'b1; req_pattern = PAT_BALN;  mode_d = 4'b1000; end
            CMD_START: if (start_q == S_IDLE) rx_d = RX_START;
            CMD_DIS:   if (start_q == S_IDLE) rx_d = RX_DIS0;
            CMD_SHUT: begin
              kill    = 1'b1;
              mode_d  = 4'b0000;
              st_d    = 1'b0;
              ch_d    = 1'b0;
              fan_d   = 1'b0;
              start_d = S_IDLE;
              timer_d = '0;
            end
            default: ;
          endcase
        end
        RX_PAUSE: if (sym == CMD_PAUSE) begin
          req_valid = 1'b1;
          mode_d    = 4'b0000;
        end
        RX_START: if (sym == CMD_PAUSE) begin
          req_valid = 1'b1;
          fan_d     = 1'b1;
          ch_d      = 1'b1;
          st_d      = 1'b0;
          timer_d   = PRE_LD;
          start_d   = S_WAIT_PC;
        end
        RX_DIS0: if (sym == CMD_PAUSE) rx_d = RX_DIS1;
        RX_DIS1: if (sym == CMD_DIS)   rx_d = RX_DIS2;
        RX_DIS2: if (sym == CMD_PAUSE) rx_d = RX_DIS3;
        RX_DIS3: if (!st_q && !ch_q) begin
          if (sym == CMD_PLUS) begin
            req_valid = 1'b1; req_pattern = PAT_PLUS; mode_d = 4'b0001;
          end else if (sym == CMD_BALP) begin
            req_valid = 1'b1; req_pattern = PAT_BALP; mode_d = 4'b0001;
          end
        end
        RX_ERROR: rx_d = (sym == CMD_SHUT) ? RX_CLR : RX_ERROR;
        RX_CLR: begin
          if (sym == CMD_SHUT && trip == '0) begin
            latch_d = '0;
            brk_d   = 1'b0;
            rx_d    = RX_IDLE;
          end else begin
            rx_d = RX_ERROR;
          end
        end
        default: ;
      endcase
    end else if (gap_q == '0) begin
      case (rx_q)
        RX_PAUSE, RX_START, RX_DIS0, RX_DIS1, RX_DIS2, RX_DIS3: rx_d = RX_IDLE;
        RX_CLR:  rx_d = RX_ERROR;
        default: ;
      endcase
    end

    if (trip != '0) begin
      kill      = 1'b1;
      req_valid = 1'b0;
      mode_d    = 4'b0000;
      st_d      = 1'b0;
      ch_d      = 1'b0;
      fan_d     = 1'b1;
      brk_d     = 1'b1;
      start_d   = S_IDLE;
      timer_d   = '0;
      rx_d      = RX_ERROR;
    end
    latch_d = latch_d | fault;

    if (led_cnt_q <= TW'(1)) begin
      led_cnt_d = (rx_q == RX_ERROR) ? LEDE_LD : LEDN_LD;
      led_d     = ~led_q;
    end else begin
      led_cnt_d = led_cnt_q - TW'(1);
      led_d     = led_q;
    end
    done_d = (rx_d == RX_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_clk_q <= 1'b0;
      rx_q      <= RX_IDLE;
      start_q   <= S_IDLE;
      timer_q   <= '0;
      gap_q     <= '0;
      led_cnt_q <= '0;
      mode_q    <= 4'b0000;
      st_q      <= 1'b0;
      ch_q      <= 1'b0;
      fan_q     <= 1'b0;
      brk_q     <= 1'b0;
      latch_q   <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bus_clk_q <= bus_clk;
      rx_q      <= rx_d;
      start_q   <= start_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      led_cnt_q <= led_cnt_d;
      mode_q    <= mode_d;
      st_q      <= st_d;
      ch_q      <= ch_d;
      fan_q     <= fan_d;
      brk_q     <= brk_d;
      latch_q   <= latch_d;
      led_q     <= led_d;
      done_q    <= done_d;
    end
  end

  bridge_deadtime #(
    .DEADTIME_CYC (DEADTIME_CYC),
    .TW           (TW)
  ) u_deadtime (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_pattern (req_pattern),
    .kill        (kill),
    .gates_out   (gates_w)
  );

  assign gates       = leg_pattern_t'(gates_w);
  assign o_top       = gates.top;
  assign o_bot       = gates.bot;
  assign o_plus      = mode_q[0];
  assign o_minus     = mode_q[1];
  assign o_pause_p   = mode_q[2];
  assign o_pause_n   = mode_q[3];
  assign o_st        = st_q;
  assign o_ch        = ch_q;
  assign o_fan       = fan_q;
  assign o_break     = brk_q;
  assign fault_latch = latch_q;
  assign led_ready   = led_q;
  assign led_done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bridge_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bridge_seq_ctrl: scoreboard bench for the H-bridge sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bridge_seq_ctrl;

  localparam int unsigned N_FAULT = 8;
  localparam int unsigned PRE     = 150;
  localparam int unsigned SET     = 10;
  localparam int unsigned DT      = 4;
  localparam int unsigned SEQ_TO  = 50;
  localparam int unsigned LEDN    = 40;
  localparam int unsigned LEDE    = 8;

  localparam logic [3:0] T_PLUS = 4'b0001, B_PLUS = 4'b0010;
  localparam logic [3:0] T_MIN  = 4'b0010, B_MIN  = 4'b0001;
  localparam logic [3:0] T_BALP = 4'b0100, B_BALP = 4'b1000;
  localparam logic [3:0] M_PLUS = 4'b0001, M_MIN  = 4'b0010;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               bus_clk = 1'b0;
  logic [2:0]         bus_data = 3'd0;
  logic [N_FAULT-1:0] fault = '0;
  logic [3:0]         o_top, o_bot;
  logic               o_plus, o_minus, o_pause_p, o_pause_n;
  logic               o_st, o_ch, o_fan, o_break;
  logic [N_FAULT-1:0] fault_latch;
  logic               led_ready, led_done;

  always #5 clk = ~clk;

  bridge_seq_ctrl #(
    .N_FAULT         (N_FAULT),
    .FAULT_MASK      (8'h7F),
    .PRECHARGE_CYC   (PRE),
    .SETTLE_CYC      (SET),
    .DEADTIME_CYC    (DT),
    .SEQ_TIMEOUT_CYC (SEQ_TO),
    .LED_NORMAL      (LEDN),
    .LED_ERROR       (LEDE),
    .TW              (32)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus_clk     (bus_clk),
    .bus_data    (bus_data),
    .fault       (fault),
    .o_top       (o_top),
    .o_bot       (o_bot),
    .o_plus      (o_plus),
    .o_minus     (o_minus),
    .o_pause_p   (o_pause_p),
    .o_pause_n   (o_pause_n),
    .o_st        (o_st),
    .o_ch        (o_ch),
    .o_fan       (o_fan),
    .o_break     (o_break),
    .fault_latch (fault_latch),
    .led_ready   (led_ready),
    .led_done    (led_done)
  );

  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
    logic [3:0] mode;   // {pause_n, pause_p, minus, plus}
    logic       st, ch, fan, brk;
    logic [7:0] latch;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t snap();
    obs_t o;
    o.top   = o_top;
    o.bot   = o_bot;
    o.mode  = {o_pause_n, o_pause_p, o_minus, o_plus};
    o.st    = o_st;
    o.ch    = o_ch;
    o.fan   = o_fan;
    o.brk   = o_break;
    o.latch = fault_latch;
    o.done  = led_done;
    return o;
  endfunction

  function automatic obs_t mk(logic [3:0] top, logic [3:0] bot, logic [3:0] mode,
                              logic st, logic ch, logic fan, logic brk,
                              logic [7:0] latch, logic done);
    obs_t o;
    o.top = top; o.bot = bot; o.mode = mode;
    o.st = st; o.ch = ch; o.fan = fan; o.brk = brk;
    o.latch = latch; o.done = done;
    return o;
  endfunction

  // Falling strobe edge lands one cycle after the rise; returns #1 after edge+1
  task automatic send_sym(input logic [2:0] s);
    @(posedge clk); #1;
    bus_data = s;
    bus_clk  = 1'b1;
    @(posedge clk); #1;
    bus_clk  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_seq4(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
    send_sym(a); send_sym(b); send_sym(c); send_sym(d);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    #12;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 0));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp || led_ready !== 1'b0) begin
      errors++; $display("FAIL reset_state: got %h led %b expected %h led 0", got, led_ready, exp);
    end
    @(negedge clk); rstn = 1'b1;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 1));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_release: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_start();
    obs_t got, exp;
    int n;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 0));
    send_sym(3'd5);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL start_prefix: got %h expected %h", got, exp); end
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 1, 1, 0, 8'h00, 1));
    send_sym(3'd0);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL start_cmd: got %h expected %h", got, exp); end
    n = 0;
    while (o_st !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== int'(PRE)) begin errors++; $display("FAIL precharge_len: got %0d cycles expected %0d", n, PRE); end
    n = 0;
    while (o_ch !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== int'(SET)) begin errors++; $display("FAIL settle_len: got %0d cycles expected %0d", n, SET); end
  endtask

  task automatic test_deadtime();
    obs_t got, exp;
    exp_q.push_back(mk(T_PLUS, B_PLUS, M_PLUS, 1, 0, 1, 0, 8'h00, 1));
    send_sym(3'd1);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL plus_cmd: got %h expected %h", got, exp); end
    for (int i = 0; i < int'(DT); i++)
      exp_q.push_back(mk(4'h0, 4'h0, M_MIN, 1, 0, 1, 0, 8'h00, 1));
    exp_q.push_back(mk(T_MIN, B_MIN, M_MIN, 1, 0, 1, 0, 8'h00, 1));
    send_sym(3'd2);
    for (int i = 0; i <= int'(DT); i++) begin
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL deadtime_c%0d: got %h expected %h", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_discharge();
    obs_t got, exp;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 1));
    send_sym(3'd6);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL shutdown: got %h expected %h", got, exp); end
    send_sym(3'd7);
    checks++;
    if (led_done !== 1'b0) begin errors++; $display("FAIL busy_done: got %b expected 0", led_done); end
    send_seq4(3'd0, 3'd7, 3'd0, 3'd3);
    exp_q.push_back(mk(T_BALP, B_BALP, M_PLUS, 0, 0, 0, 0, 8'h00, 1));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL discharge_balp: got %h expected %h", got, exp); end
  endtask

  task automatic test_timeout();
    obs_t got, exp;
    send_sym(3'd6);
    send_sym(3'd7); send_sym(3'd0); send_sym(3'd7);
    repeat (60) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 1));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_idle: got %h expected %h", got, exp); end
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 1));
    send_sym(3'd0); send_sym(3'd3);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_noeffect: got %h expected %h", got, exp); end
  endtask

  task automatic test_faults();
    obs_t got, exp;
    logic prev;
    int   n;
    send_seq4(3'd7, 3'd0, 3'd7, 3'd0);
    send_sym(3'd1);
    @(posedge clk); #1; fault = 8'h80;
    exp_q.push_back(mk(T_PLUS, B_PLUS, M_PLUS, 0, 0, 0, 0, 8'h80, 1));
    @(posedge clk); #1; fault = 8'h00;
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL masked_fault: got %h expected %h", got, exp); end
    fault = 8'h01;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 8'h81, 0));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL trip_fault: got %h expected %h", got, exp); end
    prev = led_ready; n = 0;
    while (led_ready === prev && n < 100) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 2; k++) begin
      prev = led_ready; n = 0;
      while (led_ready === prev && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== int'(LEDE)) begin errors++; $display("FAIL led_error_period%0d: got %0d expected %0d", k, n, LEDE); end
    end
  endtask

  task automatic test_clear();
    obs_t got, exp;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 8'h81, 0));
    send_sym(3'd6); send_sym(3'd6);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_blocked: got %h expected %h", got, exp); end
    fault = 8'h00;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 8'h00, 1));
    send_sym(3'd6); send_sym(3'd6);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_ok: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_in_gap();
    obs_t got, exp;
    exp_q.push_back(mk(T_PLUS, B_PLUS, M_PLUS, 0, 0, 1, 0, 8'h00, 1));
    send_seq4(3'd7, 3'd0, 3'd7, 3'd0);
    send_sym(3'd1);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL gap_setup: got %h expected %h", got, exp); end
    exp_q.push_back(mk(4'h0, 4'h0, M_PLUS, 0, 0, 1, 0, 8'h00, 1));
    send_seq4(3'd7, 3'd0, 3'd7, 3'd0);
    send_sym(3'd3);
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL gap_open: got %h expected %h", got, exp); end
    #1; rstn = 1'b0;
    #1;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 0));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp || led_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h led %b expected %h led 0", got, led_ready, exp);
    end
    @(negedge clk); rstn = 1'b1;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 1));
    repeat (10) @(posedge clk);
    #1;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pending_dropped: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_deadtime();
    test_discharge();
    test_timeout();
    test_faults();
    test_clear();
    test_reset_in_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/bridge_seq_ctrl.md
Name: bridge_seq_ctrl

Overview:
- Parametrised H-bridge sequencer: decodes strobed 3-bit commands, runs the charge/start sequence, drives the four top/bottom leg gates, latches faults and blinks status LEDs.
- Successor to the fixed-function board controller. Adds dead-time insertion between leg patterns, N configurable fault channels with per-channel masking, a multi-symbol sequence timeout, and a fault-clear command.
- Sits behind the input glitch filters: all inputs arrive already filtered and synchronous to clk.

Parameters:
- N_FAULT, 8, number of fault inputs.
- FAULT_MASK, '1 (N_FAULT bits), bit=1 means that channel trips the bridge; bit=0 latches the channel only.
- PRECHARGE_CYC, 750000000, charge-relay time before o_st asserts (15 s at 50 MHz).
- SETTLE_CYC, 50000000, time from o_st rising to o_ch falling.
- DEADTIME_CYC, 50, all-legs-off gap when one non-zero pattern replaces another.
- SEQ_TIMEOUT_CYC, 5000000, maximum gap between symbols of a multi-symbol command.
- LED_NORMAL, 50000000, led_ready half-period in normal operation.
- LED_ERROR, 6250000, led_ready half-period in ERROR.
- TW, 32, timer width; elaboration fails if any cycle parameter does not fit in TW.

Ports:
- clk, in, 1, system clock.
- rstn, in, 1, asynchronous active-low reset.
- bus_clk, in, 1, command strobe; a symbol is taken on its falling edge.
- bus_data, in, 3, command symbol.
- fault, in, N_FAULT, active-high filtered fault levels.
- o_top, out, 4, high-side gates [3:0] = TOP1..TOP4.
- o_bot, out, 4, low-side gates [3:0] = BOT1..BOT4.
- o_plus, o_minus, o_pause_p, o_pause_n, out, 1 each, mode indicators.
- o_st, o_ch, o_fan, o_break, out, 1 each.
- fault_latch, out, N_FAULT, sticky fault flags.
- led_ready, out, 1, blink output.
- led_done, out, 1, high when the receiver is idle and not in error.

Behaviour:
- Reset: every output and every internal register is 0; rx=IDLE; start=S_IDLE. Reset is asynchronous and aborts any operation in progress, including dead-time.
- Strobe: an edge is bus_clk_q=1 and bus_clk=0, where bus_clk_q is a 1-cycle registered copy. Decode happens in the edge cycle; outputs change at edge+1.
- Single-symbol commands, accepted only when start=S_IDLE, o_st=1 and o_ch=0; otherwise ignored:
  - 1 = PLUS: pattern top=0001, bot=0010; o_plus=1.
  - 2 = MINUS: pattern top=0010, bot=0001; o_minus=1.
  - 3 = BAL_P: pattern top=0100, bot=1000; o_pause_p=1.
  - 4 = BAL_N: pattern top=1000, bot=0100; o_pause_n=1.
  - The three mode indicators not selected are cleared.
- Multi-symbol commands, tracked by rx states IDLE, PAUSE, START, DIS0..DIS3, CLR:
  - 0,0 = PAUSE: pattern 0000/0000; all mode indicators cleared.
  - 5,0 = START: pattern off; o_fan=1, o_ch=1, o_st=0; timer=PRECHARGE_CYC; start→S_WAIT_PC.
  - 7,0,7,0,x = DISCHARGE, accepted only when o_st=0 and o_ch=0:
    - x=1: PLUS pattern with o_plus=1.
    - x=3: BAL_P pattern with o_plus=1.
    - Any other x: no effect.
  - A mismatched second symbol returns rx to IDLE without effect.
  - START and DISCHARGE prefixes are ignored while start≠S_IDLE.
- 6 = SHUTDOWN: accepted from rx=IDLE in any start state. Sets all gates, mode indicators, o_st, o_ch and o_fan to 0; start→S_IDLE; timer=0.
- 6,6 = CLEAR, accepted only in ERROR:
  - If (fault & FAULT_MASK)==0: fault_latch←0, o_break←0, rx→IDLE.
  - Otherwise: remain in ERROR.
- Sequence timeout: the gap counter reloads on every accepted symbol. If it expires while rx is in PAUSE, START, DIS0..DIS3 or CLR, rx returns to IDLE (ERROR for CLR) with no output change.
- Start sequence:
  - S_WAIT_PC: at timer==0, o_st=1, timer=SETTLE_CYC, start→S_WAIT_ST.
  - S_WAIT_ST: at timer==0, o_ch=0, start→S_IDLE.
  - The timer decrements every cycle and saturates at 0.
- Dead-time, applied only to gate outputs (indicators update immediately):
  - A new non-zero pattern replacing a different non-zero pattern: gates go 0 at edge+1; the new pattern appears at edge+1+DEADTIME_CYC.
  - Previous pattern zero, new pattern identical, or DEADTIME_CYC=0: immediate.
  - Another command during the gap replaces the pending pattern; the gap is not restarted.
  - An off or fault request cancels the pending pattern.
- Faults, evaluated every cycle:
  - fault_latch |= fault on all channels regardless of mask.
  - If any (fault & FAULT_MASK) bit is set: gates=0, pending pattern cleared, mode indicators=0, o_st=0, o_ch=0, o_fan=1, o_break=1, start=S_IDLE, rx=ERROR.
  - A fault overrides any command decoded in the same cycle.
  - In ERROR only CLEAR is decoded.
- LED: the counter reloads at 0 and led_ready toggles. Reload is LED_ERROR when rx=ERROR, else LED_NORMAL.
- led_done = (rx==IDLE).

Decomposition:
- Package bridge_seq_pkg holds:
  - cmd_code_t enum (PAUSE=0 … DIS=7);
  - rx_state_t and start_state_t enums;
  - leg_pattern_t struct (top, bot);
  - localparams PAT_OFF, PAT_PLUS, PAT_MINUS, PAT_BALP, PAT_BALN.
- Sub-module bridge_deadtime (params DEADTIME_CYC, TW; ports clk, rstn, req_valid, req_pattern, kill, gates_out) owns the gap counter and the pending register.

Test Plan:
Sim parameters: PRECHARGE_CYC=150, SETTLE_CYC=10, DEADTIME_CYC=4, SEQ_TIMEOUT_CYC=50, N_FAULT=8, FAULT_MASK=8'h7F.
- Send 5,0 → o_fan=o_ch=1 at edge+1; o_st=1 150 cycles later; o_ch=0 a further 10 cycles later.
- After start completes, send 1 then 2 → top/bot=0001/0010 at edge+1; on the 2, gates=0 for exactly 4 cycles, then 0010/0001; o_minus changes at edge+1.
- Send 7,0,7,0,3 with o_st=0 → top=0100, bot=1000, o_plus=1. Same sequence with a 60-cycle gap after the second 7 → no effect, rx back to IDLE.
- Drive fault[7] (unmasked-out channel) for 1 cycle while PLUS is active → fault_latch=8'h80, gates unchanged. Then fault[0] → gates=0, o_break=1, o_fan=1, led_ready toggling every LED_ERROR cycles.
- In ERROR, send 6,6 while fault[0]=1 → stays in ERROR. Release fault[0], send 6,6 → fault_latch=0, o_break=0, led_done=1.
- Assert rstn=0 during the dead-time gap → all outputs 0 immediately; after release the pending pattern never appears.
